round_sequencer: RTL and testbench

Round controller for the reaction game. It owns the LFSR's reset and enable controls and samples the LFSR value to set a random pre-target delay. It then measures reaction time in prescaled ticks, detects early presses (foul) and timeouts, and keeps a best-score register. It sits between the debounced button/start inputs, the LFSR and the display/score logic.

---
 rtl/round_sequencer.sv | 138 +++++++++++++
 tb/tb_round_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// Round controller for the reaction game: seeds the LFSR, runs a random pre-target delay,
// times the player's reaction in prescaled ticks and tracks foul, timeout and best score.
module round_sequencer #(
    parameter int unsigned LFSR_W    = 8,
    parameter int unsigned TICK_DIV  = 1000,
    parameter int unsigned MIN_DELAY = 16,
    parameter int unsigned TIMEOUT   = 2000,
    parameter int unsigned CNT_W     = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              button,
    input  logic [LFSR_W-1:0] lfsr_value,
    output logic              lfsr_reset,
    output logic              lfsr_en,
    output logic              target_on,
    output logic              busy,
    output logic [CNT_W-1:0]  result,
    output logic              result_valid,
    output logic              foul,
    output logic              timeout_flag,
    output logic [CNT_W-1:0]  best,
    output logic [2:0]        state
);

    localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned DlyW = LFSR_W + 1;

    typedef enum logic [2:0] {
        StInit  = 3'd0,
        StIdle  = 3'd1,
        StLoad  = 3'd2,
        StWait  = 3'd3,
        StReact = 3'd4,
        StDone  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [PreW-1:0]   presc_q;
    logic [DlyW-1:0]   delay_q;
    logic [CNT_W-1:0]  cnt_q, result_q, best_q;
    logic              foul_q, timeout_q, valid_q;
    logic              lfsr_reset_q, lfsr_en_q, target_on_q, busy_q;
    logic              tick, timeout_hit;
    logic [CNT_W-1:0]  press_val;

    assign tick        = (presc_q == PreW'(TICK_DIV - 1));
    // A press on a tick cycle counts that tick.
    assign press_val   = cnt_q + CNT_W'(tick);
    assign timeout_hit = tick && ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:         state_d = StIdle;
            StIdle, StDone: if (start) state_d = StLoad;
            StLoad:         state_d = StWait;
            StWait: begin
                if (button) begin
                    state_d = StDone;
                end else if (tick && delay_q == DlyW'(1)) begin
                    state_d = StReact;
                end
            end
            StReact:        if (button || timeout_hit) state_d = StDone;
            default:        state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StInit;
            presc_q      <= '0;
            delay_q      <= '0;
            cnt_q        <= '0;
            result_q     <= '0;
            best_q       <= '1;
            foul_q       <= 1'b0;
            timeout_q    <= 1'b0;
            valid_q      <= 1'b0;
            lfsr_reset_q <= 1'b1;
            lfsr_en_q    <= 1'b0;
            target_on_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= 1'b0;
            // Free-running wrap also clears the prescaler on the WAIT->REACT tick.
            presc_q      <= tick ? '0 : presc_q + 1'b1;
            lfsr_reset_q <= (state_d == StInit);
            lfsr_en_q    <= state_d inside {StIdle, StWait, StReact, StDone};
            target_on_q  <= (state_d == StReact);
            busy_q       <= state_d inside {StLoad, StWait, StReact};
            case (state_q)
                StLoad: begin
                    delay_q   <= DlyW'(MIN_DELAY) + DlyW'(lfsr_value);
                    foul_q    <= 1'b0;
                    timeout_q <= 1'b0;
                    presc_q   <= '0;
                    cnt_q     <= '0;
                end
                StWait: begin
                    if (button) begin
                        foul_q <= 1'b1;
                    end else if (tick && delay_q != DlyW'(1)) begin
                        delay_q <= delay_q - 1'b1;
                    end
                end
                StReact: begin
                    if (button) begin
                        result_q <= press_val;
                        valid_q  <= 1'b1;
                        if (press_val < best_q) best_q <= press_val;
                    end else if (timeout_hit) begin
                        timeout_q <= 1'b1;
                        result_q  <= CNT_W'(TIMEOUT);
                    end else if (tick) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign lfsr_reset   = lfsr_reset_q;
    assign lfsr_en      = lfsr_en_q;
    assign target_on    = target_on_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign foul         = foul_q;
    assign timeout_flag = timeout_q;
    assign best         = best_q;
    assign state        = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with small parameters; inputs change and outputs are
// sampled on the falling edge.
module tb_round_sequencer;

    localparam int unsigned LfsrW    = 4;
    localparam int unsigned TickDiv  = 4;
    localparam int unsigned MinDelay = 2;
    localparam int unsigned Timeout  = 10;
    localparam int unsigned CntW     = 8;

    logic             clk, reset, start, button;
    logic [LfsrW-1:0] lfsr_value;
    logic             lfsr_reset, lfsr_en, target_on, busy;
    logic [CntW-1:0]  result, best;
    logic             result_valid, foul, timeout_flag;
    logic [2:0]       state;

    int n_checks = 0;
    int n_errors = 0;

    round_sequencer #(
        .LFSR_W   (LfsrW),
        .TICK_DIV (TickDiv),
        .MIN_DELAY(MinDelay),
        .TIMEOUT  (Timeout),
        .CNT_W    (CntW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .button      (button),
        .lfsr_value  (lfsr_value),
        .lfsr_reset  (lfsr_reset),
        .lfsr_en     (lfsr_en),
        .target_on   (target_on),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .foul        (foul),
        .timeout_flag(timeout_flag),
        .best        (best),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // From IDLE/DONE: pulse start, step through LOAD and WAIT, land on REACT cycle 1.
    task automatic run_to_react(input int v, input string tag);
        int d;
        d = MinDelay + v;
        start      = 1'b1;
        lfsr_value = LfsrW'(v);
        cycles(1);
        start = 1'b0;
        check_eq({tag, "_load_state"}, state, 2);
        cycles(d * TickDiv);
        check_eq({tag, "_wait_last"}, state, 3);
        check_eq({tag, "_wait_tgt"}, target_on, 0);
        cycles(1);
        check_eq({tag, "_react"}, state, 4);
        check_eq({tag, "_tgt_on"}, target_on, 1);
    endtask

    // From REACT cycle 1: hold button during REACT cycle k, return on first DONE cycle.
    task automatic press_at(input int k);
        cycles(k - 1);
        button = 1'b1;
        cycles(1);
        button = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; button = 1'b0; lfsr_value = '0;
        cycles(2);
        check_eq("rst_state", state, 0);
        check_eq("rst_lfsr_reset", lfsr_reset, 1);
        check_eq("rst_lfsr_en", lfsr_en, 0);
        check_eq("rst_best", best, 8'hFF);
        check_eq("rst_result", result, 0);
        check_eq("rst_busy", busy, 0);
        reset = 1'b0;
        #1;
        check_eq("init_state", state, 0);
        check_eq("init_lfsr_reset", lfsr_reset, 1);
        cycles(1);
        check_eq("idle_state", state, 1);
        check_eq("idle_lfsr_en", lfsr_en, 1);
        check_eq("idle_lfsr_reset", lfsr_reset, 0);
        check_eq("idle_best", best, 8'hFF);
        button = 1'b1;
        cycles(1);
        button = 1'b0;
        check_eq("idle_btn_ignored", state, 1);

        // Normal round: delay 5 -> 20 WAIT cycles, press on REACT cycle 12 (3rd tick).
        start = 1'b1; lfsr_value = 4'd3;
        cycles(1);
        start = 1'b0;
        check_eq("r1_load", state, 2);
        check_eq("r1_load_lfsr_en", lfsr_en, 0);
        check_eq("r1_load_busy", busy, 1);
        cycles(1);
        check_eq("r1_wait_first", state, 3);
        cycles(19);
        check_eq("r1_wait_t20", state, 3);
        check_eq("r1_wait_tgt", target_on, 0);
        cycles(1);
        check_eq("r1_react_t21", state, 4);
        check_eq("r1_tgt_on", target_on, 1);
        press_at(12);
        check_eq("r1_done", state, 5);
        check_eq("r1_result", result, 3);
        check_eq("r1_valid", result_valid, 1);
        check_eq("r1_best", best, 3);
        check_eq("r1_tgt_off", target_on, 0);
        cycles(1);
        check_eq("r1_valid_pulse", result_valid, 0);

        // Second round: press between ticks after 5 ticks -> result 5, best stays 3.
        run_to_react(0, "r2");
        press_at(22);
        check_eq("r2_result", result, 5);
        check_eq("r2_valid", result_valid, 1);
        check_eq("r2_best", best, 3);

        // Foul on WAIT cycle 2.
        start = 1'b1; lfsr_value = 4'd1;
        cycles(1);
        start = 1'b0;
        cycles(1);
        button = 1'b1;
        cycles(1);
        button = 1'b0;
        check_eq("foul_state", state, 5);
        check_eq("foul_flag", foul, 1);
        check_eq("foul_tgt", target_on, 0);
        check_eq("foul_result", result, 5);
        check_eq("foul_valid", result_valid, 0);
        check_eq("foul_best", best, 3);

        // Timeout round with a start pulse in WAIT that must be ignored (delay 4 -> 16 cycles).
        start = 1'b1; lfsr_value = 4'd2;
        cycles(1);
        start = 1'b0;
        cycles(1);
        check_eq("to_foul_cleared", foul, 0);
        cycles(2);
        start = 1'b1;
        cycles(1);
        start = 1'b0;
        check_eq("to_start_ignored", state, 3);
        cycles(12);
        check_eq("to_wait_c16", state, 3);
        cycles(1);
        check_eq("to_react_c17", state, 4);
        cycles(39);
        check_eq("to_react_c40", state, 4);
        cycles(1);
        check_eq("to_state", state, 5);
        check_eq("to_flag", timeout_flag, 1);
        check_eq("to_result", result, Timeout);
        check_eq("to_valid", result_valid, 0);
        check_eq("to_best", best, 3);
        button = 1'b1;
        cycles(1);
        button = 1'b0;
        check_eq("done_btn_state", state, 5);
        check_eq("done_btn_result", result, Timeout);

        // Collision: press on the 10th tick cycle.
        run_to_react(0, "col");
        check_eq("col_to_cleared", timeout_flag, 0);
        press_at(40);
        check_eq("col_result", result, Timeout);
        check_eq("col_valid", result_valid, 1);
        check_eq("col_flag", timeout_flag, 0);
        check_eq("col_best", best, 3);

        // Reset in the middle of REACT.
        run_to_react(5, "mr");
        cycles(3);
        reset = 1'b1;
        #1;
        check_eq("mr_tgt", target_on, 0);
        check_eq("mr_state", state, 0);
        check_eq("mr_best", best, 8'hFF);
        check_eq("mr_lfsr_reset", lfsr_reset, 1);
        check_eq("mr_result", result, 0);
        cycles(1);
        reset = 1'b0;
        cycles(1);
        check_eq("mr_idle", state, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
